systolic_result_drain: RTL and testbench

//  Downstream stage of the 2x2 systolic array. Captures each 2x2 result tile
//  (c00..c11) on the array's out_valid, buffers whole tiles in a small FIFO,
//  and serialises them one element per cycle over a valid/ready stream.
//  The array has no backpressure, so this block absorbs bursts. It flags any

---
 rtl/systolic_result_drain_if.sv | 29 ++
 rtl/systolic_result_drain.sv | 162 ++++++++++++++++
 tb/tb_systolic_result_drain.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_result_drain_if.sv
// Stream bundle between the 2x2 systolic array, the result drain and its
// consumer. The drain uses the slave view; whatever drives tiles in and pulls
// elements out uses the master view.
interface systolic_result_drain_if #(
  parameter int ACC_WIDTH = 9,
  parameter int OUT_WIDTH = 8
);
  logic                 in_valid;
  logic [ACC_WIDTH-1:0] c00;
  logic [ACC_WIDTH-1:0] c01;
  logic [ACC_WIDTH-1:0] c10;
  logic [ACC_WIDTH-1:0] c11;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_row;
  logic                 out_col;
  logic                 out_last;

  modport slave (
    input  in_valid, c00, c01, c10, c11, out_ready,
    output out_valid, out_data, out_row, out_col, out_last
  );

  modport master (
    output in_valid, c00, c01, c10, c11, out_ready,
    input  out_valid, out_data, out_row, out_col, out_last
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Result drain for the 2x2 systolic array.
// Captures one 2x2 tile per in_valid cycle into a DEPTH-entry tile FIFO and
// serialises the head tile as c00, c01, c10, c11 over a valid/ready stream.
// The array cannot be stalled, so a tile arriving while the FIFO is full and
// nothing pops is dropped and the sticky overflow flag is raised.
// Build option: define RESULT_SAT_EN to saturate elements to OUT_WIDTH bits;
// without it elements are truncated to their low OUT_WIDTH bits.
//
// state | meaning
// IDLE  | no tile buffered, out_valid low
// DRAIN | head tile being serialised, out_valid high
module systolic_result_drain #(
  parameter int ACC_WIDTH = 9,
  parameter int OUT_WIDTH = 8,
  parameter int DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  systolic_result_drain_if.slave   bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  // Element 0 (c00) sits in the lowest slice so the element index selects it
  // directly.
  typedef logic [3:0][ACC_WIDTH-1:0] tile_t;
  typedef enum logic {IDLE, DRAIN} state_t;

  state_t               state_q;
  tile_t                mem [DEPTH];
  logic [PW-1:0]        rd_ptr_q;
  logic [PW-1:0]        wr_ptr_q;
  logic [1:0]           idx_q;
  logic [LW-1:0]        level_q;
  logic                 ovf_q;
  logic                 out_valid_q;
  logic [OUT_WIDTH-1:0] out_data_q;
  logic                 out_row_q;
  logic                 out_col_q;
  logic                 out_last_q;

  tile_t                in_tile;
  logic                 transfer;
  logic                 pop;
  logic                 full;
  logic                 push_ok;
  logic                 drop;
  logic [PW-1:0]        rd_nxt;
  logic [PW-1:0]        wr_nxt;
  logic [1:0]           idx_nxt;
  logic [LW-1:0]        level_nxt;
  logic                 have_next;
  tile_t                head_nxt;
  logic [ACC_WIDTH-1:0] elem_nxt;

  assign in_tile = {bus.c11, bus.c10, bus.c01, bus.c00};

`ifdef RESULT_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'd1 << OUT_WIDTH) - 64'd1);

  function automatic logic [OUT_WIDTH-1:0] reduce_elem(input logic [ACC_WIDTH-1:0] e);
    if (e > SAT_MAX) begin
      return {OUT_WIDTH{1'b1}};
    end
    return OUT_WIDTH'(e);
  endfunction
`else
  function automatic logic [OUT_WIDTH-1:0] reduce_elem(input logic [ACC_WIDTH-1:0] e);
    return OUT_WIDTH'(e);
  endfunction
`endif

  // Next-cycle FIFO bookkeeping and the element that will be presented after
  // this edge. The new head may be the tile being written right now (push into
  // an empty FIFO, or push+pop with one tile buffered), so it is bypassed from
  // the inputs rather than read from the not-yet-written storage.
  always_comb begin
    transfer  = (state_q == DRAIN) && bus.out_ready;
    pop       = transfer && (idx_q == 2'd3);
    full      = (level_q == LEVEL_FULL);
    push_ok   = bus.in_valid && (!full || pop);
    drop      = bus.in_valid && full && !pop;
    rd_nxt    = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_nxt    = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    idx_nxt   = transfer ? idx_q + 2'd1 : idx_q;
    level_nxt = level_q;
    case ({push_ok, pop})
      2'b10:   level_nxt = level_q + LW'(1);
      2'b01:   level_nxt = level_q - LW'(1);
      default: level_nxt = level_q;
    endcase
    have_next = (level_nxt != '0);
    if (push_ok && (rd_nxt == wr_ptr_q)) begin
      head_nxt = in_tile;
    end else begin
      head_nxt = mem[rd_nxt];
    end
    elem_nxt = head_nxt[idx_nxt];
  end

  // Tile storage; pointers already restart on reset so contents need no clear.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr_q] <= in_tile;
    end
  end

  // Control FSM, FIFO pointers and registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      idx_q       <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= 1'b0;
      out_col_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_nxt;
      wr_ptr_q <= wr_nxt;
      idx_q    <= idx_nxt;
      level_q  <= level_nxt;
      if (drop) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        IDLE:    if (push_ok) state_q <= DRAIN;
        DRAIN:   if (!have_next) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      out_valid_q <= have_next;
      if (have_next) begin
        out_data_q <= reduce_elem(elem_nxt);
        out_row_q  <= idx_nxt[1];
        out_col_q  <= idx_nxt[0];
        out_last_q <= (idx_nxt == 2'd3);
      end else begin
        out_data_q <= '0;
        out_row_q  <= 1'b0;
        out_col_q  <= 1'b0;
        out_last_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_last  = out_last_q;
  assign fifo_level    = level_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: directed vector table, hand sequences for
// overflow and full push+pop, then random traffic against a queue model.
module tb_systolic_result_drain;
  localparam int ACC_WIDTH = 9;
  localparam int OUT_WIDTH = 8;
  localparam int DEPTH     = 2;
  localparam int OMAX      = (1 << OUT_WIDTH) - 1;
`ifdef RESULT_SAT_EN
  localparam int W300 = 255;
`else
  localparam int W300 = 44;
`endif

  typedef logic [3:0][ACC_WIDTH-1:0] tile_t;

  typedef struct {
    int rst; int iv; int c00; int c01; int c10; int c11; int rdy;
    int ev; int ed; int erow; int ecol; int elast; int elvl; int eovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [$clog2(DEPTH):0] fifo_level;
  logic overflow;

  systolic_result_drain_if #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  systolic_result_drain #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  tile_t q[$];
  int    m_idx = 0;
  int    m_ovf = 0;

  function automatic int ref_reduce(int e);
`ifdef RESULT_SAT_EN
    return (e > OMAX) ? OMAX : e;
`else
    return e % (OMAX + 1);
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(int r, int iv, int a, int b, int c, int d, int rdy);
    rst           = (r != 0);
    bus.in_valid  = (iv != 0);
    bus.c00       = ACC_WIDTH'(a);
    bus.c01       = ACC_WIDTH'(b);
    bus.c10       = ACC_WIDTH'(c);
    bus.c11       = ACC_WIDTH'(d);
    bus.out_ready = (rdy != 0);
  endtask

  // Advance one clock: update the model from the applied inputs, then compare
  // every output against the model after the edge.
  task automatic cycle();
    tile_t t;
    int ev, ed, erow, ecol, elast;
    t = {bus.c11, bus.c10, bus.c01, bus.c00};
    if (rst) begin
      q.delete();
      m_idx = 0;
      m_ovf = 0;
    end else begin
      if (q.size() > 0 && bus.out_ready) begin
        if (m_idx == 3) begin
          void'(q.pop_front());
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (bus.in_valid) begin
        if (q.size() < DEPTH) q.push_back(t);
        else m_ovf = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    ev    = (q.size() > 0) ? 1 : 0;
    ed    = ev ? ref_reduce(int'(q[0][m_idx])) : 0;
    erow  = ev ? (m_idx / 2) : 0;
    ecol  = ev ? (m_idx % 2) : 0;
    elast = (ev && m_idx == 3) ? 1 : 0;
    n_checks++;
    if (int'(bus.out_valid) != ev || int'(bus.out_data) != ed || int'(bus.out_row) != erow ||
        int'(bus.out_col) != ecol || int'(bus.out_last) != elast ||
        int'(fifo_level) != q.size() || int'(overflow) != m_ovf) begin
      n_errors++;
      $display("FAIL model: got v=%0d d=%0d r=%0d c=%0d l=%0d lvl=%0d ovf=%0d expected v=%0d d=%0d r=%0d c=%0d l=%0d lvl=%0d ovf=%0d at %0t",
               bus.out_valid, bus.out_data, bus.out_row, bus.out_col, bus.out_last, fifo_level, overflow,
               ev, ed, erow, ecol, elast, q.size(), m_ovf, $time);
    end
  endtask

  vec_t vt[20];
  int   seen[$];
  int   exp_seq[$];

  initial begin
    //         rst iv  c00 c01 c10 c11 rdy  ev  ed  row col last lvl ovf
    vt[0]  = '{1, 1,   1,  2,  3,  4,  1,   0,  0,  0,  0,  0,   0,  0};
    vt[1]  = '{1, 1,   1,  2,  3,  4,  1,   0,  0,  0,  0,  0,   0,  0};
    vt[2]  = '{0, 1,  16, 24, 48, 64,  1,   1, 16,  0,  0,  0,   1,  0};
    vt[3]  = '{0, 0,   0,  0,  0,  0,  1,   1, 24,  0,  1,  0,   1,  0};
    vt[4]  = '{0, 0,   0,  0,  0,  0,  1,   1, 48,  1,  0,  0,   1,  0};
    vt[5]  = '{0, 0,   0,  0,  0,  0,  1,   1, 64,  1,  1,  1,   1,  0};
    vt[6]  = '{0, 0,   0,  0,  0,  0,  1,   0,  0,  0,  0,  0,   0,  0};
    vt[7]  = '{0, 1,  16, 24, 48, 64,  1,   1, 16,  0,  0,  0,   1,  0};
    vt[8]  = '{0, 0,   0,  0,  0,  0,  1,   1, 24,  0,  1,  0,   1,  0};
    vt[9]  = '{0, 0,   0,  0,  0,  0,  0,   1, 24,  0,  1,  0,   1,  0};
    vt[10] = '{0, 0,   0,  0,  0,  0,  0,   1, 24,  0,  1,  0,   1,  0};
    vt[11] = '{0, 0,   0,  0,  0,  0,  0,   1, 24,  0,  1,  0,   1,  0};
    vt[12] = '{0, 0,   0,  0,  0,  0,  1,   1, 48,  1,  0,  0,   1,  0};
    vt[13] = '{0, 0,   0,  0,  0,  0,  1,   1, 64,  1,  1,  1,   1,  0};
    vt[14] = '{0, 0,   0,  0,  0,  0,  1,   0,  0,  0,  0,  0,   0,  0};
    vt[15] = '{0, 1, 300,  1,  2,  3,  0,   1, W300, 0, 0,  0,   1,  0};
    vt[16] = '{0, 0,   0,  0,  0,  0,  1,   1,  1,  0,  1,  0,   1,  0};
    vt[17] = '{0, 0,   0,  0,  0,  0,  1,   1,  2,  1,  0,  0,   1,  0};
    vt[18] = '{0, 0,   0,  0,  0,  0,  1,   1,  3,  1,  1,  1,   1,  0};
    vt[19] = '{0, 0,   0,  0,  0,  0,  1,   0,  0,  0,  0,  0,   0,  0};

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].rst, vt[i].iv, vt[i].c00, vt[i].c01, vt[i].c10, vt[i].c11, vt[i].rdy);
      cycle();
      chk($sformatf("vec%0d.valid", i), int'(bus.out_valid), vt[i].ev);
      chk($sformatf("vec%0d.data", i),  int'(bus.out_data),  vt[i].ed);
      chk($sformatf("vec%0d.rowcol", i), int'({bus.out_row, bus.out_col}), vt[i].erow * 2 + vt[i].ecol);
      chk($sformatf("vec%0d.last", i),  int'(bus.out_last),  vt[i].elast);
      chk($sformatf("vec%0d.level", i), int'(fifo_level),    vt[i].elvl);
      chk($sformatf("vec%0d.ovf", i),   int'(overflow),      vt[i].eovf);
    end

    // Overflow: three back-to-back tiles with the consumer stalled.
    drive(0, 1, 1, 2, 3, 4, 0);     cycle();
    drive(0, 1, 5, 6, 7, 8, 0);     cycle();
    drive(0, 1, 9, 10, 11, 12, 0);  cycle();
    drive(0, 0, 0, 0, 0, 0, 0);     cycle();
    chk("ovf.level", int'(fifo_level), 2);
    chk("ovf.flag", int'(overflow), 1);
    seen.delete();
    exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8};
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      seen.push_back(int'(bus.out_data));
      cycle();
    end
    for (int i = 0; i < 8; i++) chk($sformatf("ovf.drain%0d", i), seen[i], exp_seq[i]);
    chk("ovf.idle", int'(bus.out_valid), 0);
    chk("ovf.sticky", int'(overflow), 1);
    drive(1, 0, 0, 0, 0, 0, 0);     cycle();
    chk("ovf.cleared", int'(overflow), 0);

    // Full push+pop: new tile arrives as tile A's last element transfers.
    drive(0, 1, 20, 21, 22, 23, 0); cycle();
    drive(0, 1, 30, 31, 32, 33, 0); cycle();
    chk("pp.level_full", int'(fifo_level), 2);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle();
    chk("pp.a_last_data", int'(bus.out_data), 23);
    chk("pp.a_last_flag", int'(bus.out_last), 1);
    drive(0, 1, 40, 41, 42, 43, 1); cycle();
    chk("pp.level_kept", int'(fifo_level), 2);
    chk("pp.no_ovf", int'(overflow), 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    seen.delete();
    exp_seq = '{30, 31, 32, 33, 40, 41, 42, 43};
    for (int i = 0; i < 8; i++) begin
      seen.push_back(int'(bus.out_data));
      cycle();
    end
    for (int i = 0; i < 8; i++) chk($sformatf("pp.drain%0d", i), seen[i], exp_seq[i]);
    chk("pp.idle_level", int'(fifo_level), 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0) ? 1 : 0,
            ($urandom_range(0, 99) < 35) ? 1 : 0,
            int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
            int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
            ($urandom_range(0, 99) < 65) ? 1 : 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
